inv_round_key_gen: RTL
======================

// Module: inv_round_key_gen
// PURPOSE
//  Sequential AES-128 decryption round-key source: takes the cipher key, runs the key
//  schedule forward to round 10, then steps backward, delivering round keys 10,9,..,0.
//  Uses a valid/ready handshake; feeds the inverse-cipher datapath (AddRoundKey).
//  Reuses sbox_sync, so each schedule step costs 2 cycles.
// PARAMETERS
//  NUM_ROUNDS  10  rounds of AES-128; only 10 is legal (RCON table covers rounds 1..10)
// PORTS
//  clk       in   1    single clock; all state updates on rising edge
//  reset     in   1    asynchronous, active-high; clears all state immediately
//  start     in   1    begin a new schedule; sampled only in IDLE
//  key_in    in   128  cipher key, [127:96]=w0 .. [31:0]=w3; captured on accepted start
//  rk        out  128  current round key, same word order; meaningful only when rk_valid=1
//  rk_round  out  4    round index of rk (10 down to 0)
//  rk_valid  out  1    rk/rk_round valid
//  rk_ready  in   1    consumer accepts rk when rk_valid & rk_ready at a clock edge
//  busy      out  1    high in every state except IDLE
//  done      out  1    one-cycle pulse after round-0 key is accepted
// BEHAVIOUR
//  Reset values: rk=0, rk_round=0, rk_valid=0, busy=0, done=0, state=IDLE, round ctr=0.
//  Key register K = {a,b,c,d} (32-bit words). RCON[r] = {01,02,04,08,10,20,40,80,1b,36}[r-1]<<24.
//  States:
//   IDLE: start=1 -> K<=key_in, ctr<=0, FWD_SUB. start=0 -> stay.
//   FWD_SUB: sbox_sync inputs = RotWord(d) (bytes [23:0],[31:24]) -> FWD_XOR.
//   FWD_XOR: ctr<=ctr+1; a'=a^S^RCON[ctr+1], b'=b^a', c'=c^b', d'=d^c' (S = sbox out);
//    if ctr+1==10 -> OUT else FWD_SUB.
//   OUT: rk_valid=1, rk=K, rk_round=ctr. Hold K, ctr stable while rk_ready=0.
//    Handshake with ctr>0 -> BWD_SUB. Handshake with ctr==0 -> IDLE, done=1 next cycle.
//   BWD_SUB: t=d^c; sbox_sync inputs = RotWord(t) -> BWD_XOR.
//   BWD_XOR: d'=d^c, c'=c^b, b'=b^a, a'=a^S^RCON[ctr]; ctr<=ctr-1 -> OUT.
//  Latency: start edge E -> first rk_valid after edge E+20 (10 fwd steps x 2 cycles).
//   Handshake edge H -> next rk_valid after edge H+2; rk_valid low for exactly 2 cycles.
//   rk_ready held high: one key per 3 cycles; full sequence 20+11*3-2 = 51 cycles.
//  rk_valid is registered (asserted from state OUT); never depends combinationally on rk_ready.
//  rk, rk_round stable throughout OUT until handshake (AXI-style: no retraction).
//  start outside IDLE ignored (no restart, no queue); key_in changes after capture ignored.
//  start in IDLE same cycle as done pulse: accepted normally.
//  reset mid-sequence (any state): all outputs to reset values at once; next start is a
//   clean run (no stale K or ctr).
//  ctr never wraps: range 0..10; decrement only in BWD_XOR with ctr>=1.
//  All XORs 32-bit bitwise; no carries. rk = K directly (no extra output stage).
// TESTING
//  T1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> first rk valid 20 cycles
//     after start: d014f9a8c9ee2589e13f0cc8b6630ca6, rk_round=10.
//  T2 same run -> round 9 ac7766f319fadc2128d12941575c006e, round 1
//     a0fafe1788542cb123a339392a6c7605, round 0 = key_in; done pulse once; busy low after.
//  T3 backpressure: ready=0 for 7 cycles at round 5 -> rk/rk_round/rk_valid stable;
//     sequence resumes unchanged; total keys delivered = 11, no repeats or skips.
//  T4 start pulsed and key_in changed while busy -> no effect; outputs match T1/T2 values.
//  T5 reset asserted in BWD_XOR (round 6) -> outputs 0 asynchronously; new start with
//     key 000102030405060708090a0b0c0d0e0f -> round 10 key 13111d7fe3944a17f307a78b4d2b30c5.
//  T6 random keys vs reference model (forward expansion reversed), ready randomized ->
//     all 11 keys match; busy/done/rk_valid timing per rules above.

Source files
------------

// File: rtl/inv_round_key_gen.sv
// AES-128 decryption round-key source.
// The cipher key is expanded forward to round 10. The schedule is then run backward,
// and the round keys are handed out in the order 10, 9, .., 0 over a valid/ready
// handshake. A registered S-box (sbox_sync) is shared by both directions, so each
// schedule step takes two cycles.

// Four-byte AES S-box with a registered output (one cycle latency)
module sbox_sync (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    localparam int unsigned BYTES = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Substitute each byte of the input word and register the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                dout[8*i +: 8] <= SBOX[din[8*i +: 8]];
            end
        end
    end

endmodule

// Round-key sequencer: forward expansion to the last round, then backward stepping
module inv_round_key_gen #(
    parameter int unsigned NUM_ROUNDS = 10   // AES-128 only; the RCON table covers rounds 1..10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CTR_W  = 4;
    localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FWD_SUB = 3'd1,
        FWD_XOR = 3'd2,
        OUT     = 3'd3,
        BWD_SUB = 3'd4,
        BWD_XOR = 3'd5
    } state_t;

    state_t              state;
    logic [127:0]        key_reg;
    logic [CTR_W-1:0]    ctr;

    logic [WORD_W-1:0]   wa, wb, wc, wd;
    logic [WORD_W-1:0]   sbox_in_c;
    logic [WORD_W-1:0]   sbox_out;
    logic [CTR_W-1:0]    ctr_inc_c;
    logic [WORD_W-1:0]   fa_c, fb_c, fc_c, fd_c;
    logic [WORD_W-1:0]   ba_c, bb_c, bc_c, bd_c;

    // Rotate a word left by one byte
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    // Round constant for rounds 1..10, placed in the most significant byte
    function automatic logic [WORD_W-1:0] rcon(input logic [CTR_W-1:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return {v, 24'h000000};
    endfunction

    assign wa = key_reg[127:96];
    assign wb = key_reg[95:64];
    assign wc = key_reg[63:32];
    assign wd = key_reg[31:0];

    assign ctr_inc_c = ctr + CTR_W'(1);

    // Backward steps recover the previous last word (d^c) before substituting it
    assign sbox_in_c = (state == BWD_SUB) ? rot_word(wd ^ wc) : rot_word(wd);

    sbox_sync u_sbox (
        .clk   (clk),
        .reset (reset),
        .din   (sbox_in_c),
        .dout  (sbox_out)
    );

    // Next key when stepping forward one round
    always_comb begin
        fa_c = wa ^ sbox_out ^ rcon(ctr_inc_c);
        fb_c = wb ^ fa_c;
        fc_c = wc ^ fb_c;
        fd_c = wd ^ fc_c;
    end

    // Previous key when stepping backward one round
    always_comb begin
        bd_c = wd ^ wc;
        bc_c = wc ^ wb;
        bb_c = wb ^ wa;
        ba_c = wa ^ sbox_out ^ rcon(ctr);
    end

    // Sequencer state, key register, round counter and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            key_reg  <= '0;
            ctr      <= '0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        ctr     <= '0;
                        busy    <= 1'b1;
                        state   <= FWD_SUB;
                    end
                end
                FWD_SUB: begin
                    state <= FWD_XOR;
                end
                FWD_XOR: begin
                    key_reg <= {fa_c, fb_c, fc_c, fd_c};
                    ctr     <= ctr_inc_c;
                    if (ctr_inc_c == LAST_ROUND) begin
                        rk_valid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        state <= FWD_SUB;
                    end
                end
                OUT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (ctr == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= BWD_SUB;
                        end
                    end
                end
                BWD_SUB: begin
                    state <= BWD_XOR;
                end
                BWD_XOR: begin
                    key_reg  <= {ba_c, bb_c, bc_c, bd_c};
                    ctr      <= ctr - CTR_W'(1);
                    rk_valid <= 1'b1;
                    state    <= OUT;
                end
                default: begin
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign rk       = key_reg;
    assign rk_round = ctr;

endmodule
